// File: rtl/edit_mem_freeb_arb.sv
// Free-buffer arbiter: shares one edit-memory free-buffer controller
// between NREQ processing units for allocation and release.
module edit_mem_freeb_arb #(
  parameter int NREQ       = 4,
  parameter int REQ_NBITS  = 2,
  parameter int BPTR_NBITS = 8,
  parameter int QUOTA      = 16,
  parameter int RSP_LAT    = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_freeb_init_i,
  input  logic [NREQ-1:0]            req_alloc_i,
  output logic [NREQ-1:0]            req_grant_o,
  output logic [NREQ-1:0]            rsp_valid_o,
  output logic [BPTR_NBITS-1:0]      rsp_ptr_o,
  output logic                       rsp_available_o,
  input  logic [NREQ-1:0]            rel_valid_i,
  input  logic [NREQ*BPTR_NBITS-1:0] rel_ptr_i,
  output logic [NREQ-1:0]            rel_ready_o,
  output logic                       freeb_init_o,
  output logic                       pu_buf_req_o,
  input  logic                       pu_buf_valid_i,
  input  logic [BPTR_NBITS-1:0]      pu_buf_ptr_i,
  input  logic                       pu_buf_available_i,
  output logic                       rel_buf_valid_o,
  output logic [BPTR_NBITS-1:0]      rel_buf_ptr_o,
  input  logic                       freeb_init_done_i,
  output logic                       arb_ready_o,
  output logic [NREQ-1:0]            quota_err_o
);

  localparam int CW = BPTR_NBITS + 1;

  typedef enum logic [1:0] {
    ARB_WAIT_DONE,
    ARB_RUN,
    ARB_INIT,
    ARB_WAIT_DROP
  } state_e;

  state_e state_q, state_d;
  logic   run, init;

  logic [NREQ-1:0]      req_grant_q, req_grant_d, elig;
  logic [REQ_NBITS-1:0] gid, gid_q, grr_q, grr_d;
  logic                 gnt_any;

  logic [NREQ-1:0]      rel_sel;
  logic [REQ_NBITS-1:0] rid, rrr_q, rrr_d;
  logic                 rel_any;

  logic [RSP_LAT-1:0]   sr_v_q;
  logic [REQ_NBITS-1:0] sr_id_q [RSP_LAT];
  logic                 hit;
  logic [REQ_NBITS-1:0] hid;

  logic [CW-1:0] cnt_q  [NREQ];
  logic [CW-1:0] cnt_d  [NREQ];
  logic [1:0]    pend_q [NREQ];
  logic [1:0]    pend_d [NREQ];
  logic [NREQ-1:0] inc, dec, err_q, err_d;

  logic [NREQ-1:0]       rsp_valid_q;
  logic [BPTR_NBITS-1:0] rsp_ptr_q;
  logic                  rsp_av_q;
  logic                  rel_buf_valid_q;
  logic [BPTR_NBITS-1:0] rel_buf_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_WAIT_DONE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_WAIT_DONE: if (freeb_init_done_i)  state_d = ARB_RUN;
      ARB_RUN:       if (cfg_freeb_init_i)   state_d = ARB_INIT;
      ARB_INIT:                              state_d = ARB_WAIT_DROP;
      ARB_WAIT_DROP: if (!freeb_init_done_i) state_d = ARB_WAIT_DONE;
      default:                               state_d = ARB_WAIT_DONE;
    endcase
  end

  always_comb begin
    run          = (state_q == ARB_RUN);
    init         = (state_q == ARB_INIT);
    arb_ready_o  = run;
    freeb_init_o = init;
  end

  // A grant last cycle blocks this one: controller paces one prefetch per 2 cycles
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_alloc_i[i] && run && !(|req_grant_q)
        && (({1'b0, cnt_q[i]} + (CW+1)'(pend_q[i])) < (CW+1)'(QUOTA));
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gid     = grr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && elig[grr_q + REQ_NBITS'(k)]) begin
        gnt_any = 1'b1;
        gid     = grr_q + REQ_NBITS'(k);
      end
    end
    req_grant_d      = '0;
    req_grant_d[gid] = gnt_any;
    grr_d            = gnt_any ? gid + 1'b1 : grr_q;
  end

  always_comb begin
    rel_any = 1'b0;
    rid     = rrr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!rel_any && rel_valid_i[rrr_q + REQ_NBITS'(k)]) begin
        rel_any = 1'b1;
        rid     = rrr_q + REQ_NBITS'(k);
      end
    end
    rel_sel      = '0;
    rel_sel[rid] = rel_any;
    rrr_d        = rel_any ? rid + 1'b1 : rrr_q;
  end

  assign rel_ready_o = rel_sel;

  // Response belongs to whoever was granted RSP_LAT+1 cycles ago
  assign hit = pu_buf_valid_i && sr_v_q[RSP_LAT-1];
  assign hid = sr_id_q[RSP_LAT-1];

  always_comb begin
    inc   = '0;
    dec   = '0;
    err_d = err_q;
    for (int i = 0; i < NREQ; i++) begin
      inc[i] = run && hit && (hid == REQ_NBITS'(i)) && pu_buf_available_i;
      dec[i] = run && rel_any && (rid == REQ_NBITS'(i));
      pend_d[i] = pend_q[i]
        + 2'(gnt_any && (gid == REQ_NBITS'(i)))
        - 2'(hit && (hid == REQ_NBITS'(i)));
      cnt_d[i] = cnt_q[i];
      if (init) begin
        cnt_d[i] = '0;
      end else if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) err_d[i] = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_grant_q     <= '0;
      gid_q           <= '0;
      grr_q           <= '0;
      rrr_q           <= '0;
      sr_v_q          <= '0;
      err_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_ptr_q       <= '0;
      rsp_av_q        <= 1'b0;
      rel_buf_valid_q <= 1'b0;
      rel_buf_ptr_q   <= '0;
      for (int i = 0; i < RSP_LAT; i++) sr_id_q[i] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      req_grant_q <= req_grant_d;
      gid_q       <= gid;
      grr_q       <= grr_d;
      rrr_q       <= rrr_d;
      err_q       <= err_d;
      sr_v_q[0]   <= |req_grant_q;
      sr_id_q[0]  <= gid_q;
      for (int i = 1; i < RSP_LAT; i++) begin
        sr_v_q[i]  <= sr_v_q[i-1];
        sr_id_q[i] <= sr_id_q[i-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pend_q[i] <= pend_d[i];
      end
      rsp_valid_q <= hit ? (NREQ'(1) << hid) : '0;
      if (hit) begin
        rsp_ptr_q <= pu_buf_ptr_i;
        rsp_av_q  <= pu_buf_available_i;
      end
      rel_buf_valid_q <= rel_any;
      if (rel_any) begin
        rel_buf_ptr_q <= rel_ptr_i[int'(rid)*BPTR_NBITS +: BPTR_NBITS];
      end
    end
  end

  assign req_grant_o     = req_grant_q;
  assign pu_buf_req_o    = |req_grant_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_ptr_o       = rsp_ptr_q;
  assign rsp_available_o = rsp_av_q;
  assign rel_buf_valid_o = rel_buf_valid_q;
  assign rel_buf_ptr_o   = rel_buf_ptr_q;
  assign quota_err_o     = err_q;

endmodule

// File: tb/tb_edit_mem_freeb_arb.sv
// Bench for edit_mem_freeb_arb: controller model, queue scoreboard and a
// rule-level reference model of grants, quotas and releases.
module tb_edit_mem_freeb_arb;
  localparam int N   = 4;
  localparam int RB  = 2;
  localparam int BW  = 8;
  localparam int Q   = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg = 1'b0;
  logic [N-1:0] req_alloc = '0;
  logic [N-1:0] rel_valid = '0;
  logic [N*BW-1:0] rel_ptr = '0;
  logic [N-1:0] req_grant, rsp_valid, rel_ready, quota_err;
  logic [BW-1:0] rsp_ptr, rel_buf_ptr;
  logic [BW-1:0] pu_ptr = '0;
  logic rsp_av, freeb_init, pu_req, rel_buf_valid, arb_ready;
  logic pu_valid = 1'b0;
  logic pu_av = 1'b0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  edit_mem_freeb_arb #(
    .NREQ(N), .REQ_NBITS(RB), .BPTR_NBITS(BW),
    .QUOTA(Q), .RSP_LAT(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_freeb_init_i(cfg),
    .req_alloc_i(req_alloc), .req_grant_o(req_grant),
    .rsp_valid_o(rsp_valid), .rsp_ptr_o(rsp_ptr),
    .rsp_available_o(rsp_av),
    .rel_valid_i(rel_valid), .rel_ptr_i(rel_ptr),
    .rel_ready_o(rel_ready),
    .freeb_init_o(freeb_init), .pu_buf_req_o(pu_req),
    .pu_buf_valid_i(pu_valid), .pu_buf_ptr_i(pu_ptr),
    .pu_buf_available_i(pu_av),
    .rel_buf_valid_o(rel_buf_valid), .rel_buf_ptr_o(rel_buf_ptr),
    .freeb_init_done_i(done), .arb_ready_o(arb_ready),
    .quota_err_o(quota_err)
  );

  typedef struct {
    int due;
    int id;
    int ptr;
    int av;
  } exp_t;

  exp_t q_gnt[$];
  exp_t q_rsp[$];
  exp_t q_rel[$];
  exp_t infl[$];
  exp_t me;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -1;

  // controller model
  int c_ptr[int];
  int c_av[int];
  int k_req   = 0;
  int rise_at = 10;
  int drop_at = -1;
  bit av_tab[512];

  // reference model: 0 wait_done, 1 run, 2 init, 3 wait_drop
  int ms = 0;
  int cnt[N];
  int pend[N];
  bit merr[N];
  bit mprev = 0;
  int gst = 0;
  int rst_rr = 0;
  int kg = 0;
  int held[N][$];
  bit rel_flag[N];

  logic [N-1:0]    nx_req = '0;
  logic [N-1:0]    nx_rel_valid = '0;
  logic [N*BW-1:0] nx_rel_ptr = '0;
  logic            nx_cfg = 1'b0;

  function automatic int fptr(int k);
    return (k * 37 + 5) & 255;
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  task automatic issue_rel(int i);
    nx_rel_valid[i] = 1'b1;
    nx_rel_ptr[i*BW +: BW] = BW'(held[i][0]);
    rel_flag[i] = 1'b1;
  endtask

  task automatic step();
    int acc, g, e, ii, dc;
    bit inc[N];
    @(posedge clk);
    #1;
    cyc++;
    req_alloc = nx_req;
    rel_valid = nx_rel_valid;
    rel_ptr   = nx_rel_ptr;
    cfg       = nx_cfg;
    if (cyc == rise_at) done = 1'b1;
    if (cyc == drop_at) done = 1'b0;
    if (c_ptr.exists(cyc)) begin
      pu_valid = 1'b1;
      pu_ptr   = BW'(c_ptr[cyc]);
      pu_av    = c_av[cyc][0];
    end else begin
      pu_valid = ($urandom_range(0, 7) == 0);
      pu_ptr   = BW'($urandom);
      pu_av    = 1'($urandom);
    end
    if (pu_req) begin
      c_ptr[cyc+LAT] = fptr(k_req);
      c_av[cyc+LAT]  = int'(av_tab[k_req % 512]);
      k_req++;
    end
    if (freeb_init) begin
      drop_at = cyc + 2;
      rise_at = cyc + 8;
    end
    #1;
    chk("arb_ready", int'(arb_ready), int'(ms == 1));
    chk("freeb_init", int'(freeb_init), int'(ms == 2));
    e = 0;
    for (int i = 0; i < N; i++) if (merr[i]) e |= (1 << i);
    chk("quota_err", int'(quota_err), e);
    acc = -1;
    for (int k = 0; k < N; k++) begin
      ii = (rst_rr + k) % N;
      if (acc < 0 && rel_valid[ii]) acc = ii;
    end
    chk("rel_ready", int'(rel_ready), (acc < 0) ? 0 : (1 << acc));
    if (acc >= 0) begin
      q_rel.push_back('{cyc + 1, acc, int'(rel_ptr[acc*BW +: BW]), 0});
      rst_rr = (acc + 1) % N;
      nx_rel_valid[acc] = 1'b0;
      if (rel_flag[acc]) begin
        rel_flag[acc] = 1'b0;
        if (held[acc].size() > 0) void'(held[acc].pop_front());
      end
    end
    g = -1;
    if (ms == 1 && !mprev) begin
      for (int k = 0; k < N; k++) begin
        ii = (gst + k) % N;
        if (g < 0 && req_alloc[ii] && (cnt[ii] + pend[ii] < Q)) g = ii;
      end
    end
    mprev = (g >= 0);
    for (int i = 0; i < N; i++) inc[i] = 1'b0;
    while (infl.size() > 0 && infl[0].due == cyc) begin
      me = infl.pop_front();
      pend[me.id]--;
      if (ms == 1 && me.av != 0) begin
        inc[me.id] = 1'b1;
        held[me.id].push_back(me.ptr);
      end
    end
    if (g >= 0) begin
      // grant decided now: visible next cycle, response 5 cycles from now
      q_gnt.push_back('{cyc + 1, g, 0, 0});
      q_rsp.push_back('{cyc + 5, g, fptr(kg), int'(av_tab[kg % 512])});
      infl.push_back('{cyc + 4, g, fptr(kg), int'(av_tab[kg % 512])});
      pend[g]++;
      kg++;
      gst = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      dc = (ms == 1 && acc == i) ? 1 : 0;
      if (ms == 2) begin
        cnt[i] = 0;
        held[i].delete();
        rel_flag[i] = 1'b0;
      end else if (ms == 1) begin
        if (dc == 1 && !inc[i] && cnt[i] == 0) merr[i] = 1'b1;
        cnt[i] = cnt[i] + int'(inc[i]) - dc;
        if (cnt[i] < 0) cnt[i] = 0;
      end
    end
    case (ms)
      0: if (done) ms = 1;
      1: if (cfg) ms = 2;
      2: ms = 3;
      default: if (!done) ms = 0;
    endcase
  endtask

  // monitor: pops an expectation whenever one falls due
  always @(negedge clk) begin
    if (cyc >= 0) begin
      if (q_gnt.size() > 0 && q_gnt[0].due == cyc) begin
        me = q_gnt.pop_front();
        chk("req_grant", int'(req_grant), 1 << me.id);
        chk("pu_buf_req", int'(pu_req), 1);
      end else if (req_grant != '0 || pu_req) begin
        chk("unexp_grant", int'(req_grant) | (int'(pu_req) << 4), 0);
      end
      if (q_rsp.size() > 0 && q_rsp[0].due == cyc) begin
        me = q_rsp.pop_front();
        chk("rsp_valid", int'(rsp_valid), 1 << me.id);
        chk("rsp_ptr", int'(rsp_ptr), me.ptr);
        chk("rsp_available", int'(rsp_av), me.av);
      end else if (rsp_valid != '0) begin
        chk("unexp_rsp", int'(rsp_valid), 0);
      end
      if (q_rel.size() > 0 && q_rel[0].due == cyc) begin
        me = q_rel.pop_front();
        chk("rel_buf_valid", int'(rel_buf_valid), 1);
        chk("rel_buf_ptr", int'(rel_buf_ptr), me.ptr);
      end else if (rel_buf_valid) begin
        chk("unexp_rel", int'(rel_buf_valid), 0);
      end
    end
  end

  initial begin
    bit ok;
    for (int k = 0; k < 512; k++) begin
      if (k < 8)       av_tab[k] = 1'b1;
      else if (k == 9) av_tab[k] = 1'b0;
      else             av_tab[k] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      pend[i] = 0;
      merr[i] = 1'b0;
      rel_flag[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", int'(|{req_grant, rsp_valid, rel_ready, quota_err,
      freeb_init, pu_req, rel_buf_valid, arb_ready, rsp_av,
      rsp_ptr, rel_buf_ptr}), 0);
    @(negedge clk);
    rst = 1'b0;

    // idle until the controller reports done at cycle 10
    repeat (11) step();

    // release from requester 2 while it holds nothing
    nx_rel_valid[2] = 1'b1;
    nx_rel_ptr[2*BW +: BW] = 8'h2A;
    step();

    // all requesters: round-robin fills every quota
    nx_req = 4'b1111;
    repeat (20) step();
    nx_req = 4'b0000;
    repeat (6) step();

    // simultaneous releases from 1 and 3
    if (held[1].size() > 0) issue_rel(1);
    if (held[3].size() > 0) issue_rel(3);
    for (int t = 0; t < 6 && nx_rel_valid != '0; t++) step();
    chk("rel_pair_drain", int'(nx_rel_valid), 0);

    nx_req = 4'b0010;
    repeat (12) step();

    // random traffic
    for (int t = 0; t < 400; t++) begin
      nx_req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!nx_rel_valid[i] && held[i].size() > 0 && $urandom_range(0, 3) == 0)
          issue_rel(i);
      end
      step();
    end

    // drain holdings, then re-init with two grants in flight
    nx_req = '0;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      for (int i = 0; i < N; i++)
        if (!nx_rel_valid[i] && held[i].size() > 0) issue_rel(i);
      ok = (infl.size() == 0) && (nx_rel_valid == '0);
      for (int i = 0; i < N; i++) if (held[i].size() > 0) ok = 1'b0;
      if (!ok) step();
    end
    chk("drain_bound", int'(ok), 1);
    nx_req = 4'b1111;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      if (ms == 1 && infl.size() == 2) ok = 1'b1;
      else step();
    end
    chk("init_setup_bound", int'(ok), 1);
    nx_cfg = 1'b1;
    step();
    nx_cfg = 1'b0;
    repeat (40) step();

    nx_req = '0;
    repeat (10) step();
    chk("queues_empty", q_gnt.size() + q_rsp.size() + q_rel.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
